ifid_queue: RTL and testbench
=============================

IFID_QUEUE -- requirements
Module: ifid_queue

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  INSTR_W  32  instruction width, >= 32
  PC_W     32  next-PC width
  DEPTH    4   entry count, power of two, >= 2
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  CLK        in   1                  single clock, rising edge
  RST        in   1                  reset, asynchronous, active-high
  flush      in   1                  discard all entries (branch/jump redirect)
  ihit       in   1                  fetch push strobe
  instr_in   in   INSTR_W            fetched instruction
  npc_in     in   PC_W               PC+4 of fetched instruction
  pop        in   1                  decode consumes head entry
  instr_out  out  INSTR_W            head instruction; 0 (NOP) when empty
  npc_out    out  PC_W               head next-PC; 0 when empty
  valid_out  out  1                  queue non-empty
  full       out  1                  count == DEPTH
  count      out  $clog2(DEPTH+1)    occupied entries
  halt_out   out  1                  valid_out and instr_out[31:26] == 6'b111111
  halt_lock  out  1                  halt opcode enqueued; pushes blocked
  overflow   out  1                  sticky: push rejected while full
  underflow  out  1                  sticky: pop while empty

Function
REQ-003 Storage SHALL be a circular buffer of DEPTH entries {instr, npc} with read pointer, write pointer, and count registers.
REQ-004 Pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 without extra logic.
REQ-005 Outputs SHALL be show-ahead: instr_out/npc_out present the head entry combinationally from storage in the same cycle valid_out is 1.
REQ-006 A push SHALL be accepted when ihit=1, flush=0, halt_lock=0, and (full=0 or pop accepted this cycle).
REQ-007 A pop SHALL be accepted when pop=1, flush=0, and valid_out=1.
REQ-008 When push and pop are accepted in the same cycle, count SHALL be unchanged and both pointers SHALL advance, including at count==DEPTH and count==1.
REQ-009 Latency SHALL be one cycle: an entry pushed at edge N is visible at instr_out after edge N when the queue was empty.
REQ-010 flush SHALL take priority over every other event: at the next edge count, both pointers, and halt_lock go to 0, and the same-cycle push and pop are discarded.
REQ-011 ihit with full=1 and no accepted pop SHALL drop the instruction, leave state unchanged, and set overflow.
REQ-012 pop with valid_out=0 and flush=0 SHALL leave state unchanged and set underflow.
REQ-013 overflow and underflow SHALL clear only on RST; flush SHALL NOT clear them.
REQ-014 An accepted push whose instr_in[31:26]==6'b111111 SHALL set halt_lock at that edge.
REQ-015 halt_lock SHALL block further pushes until flush or RST.
REQ-016 Entries already queued, including the halt entry, SHALL still drain normally while halt_lock=1.
REQ-017 halt_out SHALL be combinational from the head entry and SHALL be 0 when empty.
REQ-018 Storage contents SHALL not be cleared by flush; valid_out=0 masks them, and instr_out/npc_out SHALL read 0 when empty.

Reset
REQ-019 While RST=1, asynchronously and independent of CLK: count=0, pointers=0, halt_lock=0, overflow=0, underflow=0, so valid_out=0, full=0, instr_out=0, npc_out=0, halt_out=0.
REQ-020 RST asserted mid-operation SHALL abandon all queued entries.
REQ-021 After RST deasserts, the first CLK edge SHALL accept a push normally.
REQ-022 Storage arrays SHALL need no reset.

Verification
REQ-023 Fill and drain, DEPTH=4:
  - stimulus: push 0x20010001..0x20010004 with npc 4,8,12,16
  - response: full=1 and count=4; then pop x4 gives the same order with npc 4..16, ends valid_out=0, instr_out=0
REQ-024 Simultaneous push/pop while full:
  - stimulus: ihit=1, pop=1, instr_in=0x8C220000
  - response: count stays 4, head advances, 0x8C220000 appears after 3 more pops, overflow=0
REQ-025 Overflow/underflow:
  - stimulus: push while full with pop=0, then drain and pop on empty
  - response: dropped instruction never appears; overflow=1 and underflow=1 and both hold after flush
REQ-026 Flush priority:
  - stimulus: with count=3, assert flush+ihit+pop in one cycle
  - response: next cycle count=0, valid_out=0, pushed instruction absent
REQ-027 Halt:
  - stimulus: push 0xFC000000, then push 0x00000020
  - response: halt_lock=1, second push ignored (count=1), halt_out=1 at head; flush then clears halt_lock and the next push is accepted
REQ-028 Asynchronous reset:
  - stimulus: assert RST between clock edges with count=2
  - response: valid_out=0 and count=0 immediately, before the next CLK edge

Source files
------------

// File: rtl/ifid_queue.sv
// ifid_queue: fetch-to-decode instruction queue.
// A small circular buffer of {instruction, next-PC} entries between the IF and
// ID stages. The head entry is shown ahead combinationally. A branch or jump
// redirect (flush) empties the queue. A halt opcode stops any further fetch
// pushes until the next flush or reset.
//
// Handshake semantics, both sides:
//   push side: ihit is a strobe that is never back-pressured. It is accepted
//              when flush=0, halt_lock=0, and there is room. A full queue
//              counts as having room when a pop is accepted in the same cycle.
//              Anything else drops the instruction. A drop caused by fullness
//              sets the sticky overflow flag.
//   pop side:  pop is accepted when flush=0 and valid_out=1. A pop on an empty
//              queue is ignored and sets the sticky underflow flag.
//   flush wins over both sides at the same edge.
module ifid_queue #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int DEPTH   = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         flush,
  input  logic                         ihit,
  input  logic [INSTR_W-1:0]           instr_in,
  input  logic [PC_W-1:0]              npc_in,
  input  logic                         pop,
  output logic [INSTR_W-1:0]           instr_out,
  output logic [PC_W-1:0]              npc_out,
  output logic                         valid_out,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         halt_out,
  output logic                         halt_lock,
  output logic                         overflow,
  output logic                         underflow
);

  // Pointer and count widths. DEPTH is a power of two, so the pointers wrap
  // from DEPTH-1 back to 0 by plain binary overflow.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [5:0]    HALT_OP = 6'b111111;

  // Entry storage. It has no reset: the count masks stale contents.
  logic [INSTR_W-1:0] r_instr_mem [DEPTH];
  logic [PC_W-1:0]    r_npc_mem   [DEPTH];

  // Control state.
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_halt_lock;
  logic          r_overflow;
  logic          r_underflow;

  // Derived status and accept strobes.
  logic               w_empty;
  logic               w_full;
  logic               w_pop_acc;
  logic               w_push_acc;
  logic               w_push_drop_full;
  logic               w_pop_on_empty;
  logic               w_push_is_halt;
  logic [INSTR_W-1:0] w_head_instr;
  logic [PC_W-1:0]    w_head_npc;

  // Status, accept decisions and error events. Everything here is derived
  // from the current state and inputs.
  always_comb begin
    w_empty          = (r_count == '0);
    w_full           = (r_count == C_DEPTH);
    w_pop_acc        = pop && !flush && !w_empty;
    w_push_acc       = ihit && !flush && !r_halt_lock && (!w_full || w_pop_acc);
    w_push_drop_full = ihit && !flush && w_full && !w_pop_acc;
    w_pop_on_empty   = pop && !flush && w_empty;
    w_push_is_halt   = (instr_in[31:26] == HALT_OP);
  end

  // Show-ahead head read. The output is forced to zero (NOP) when empty so that
  // stale storage never leaks into decode.
  always_comb begin
    w_head_instr = r_instr_mem[r_rd_ptr];
    w_head_npc   = r_npc_mem[r_rd_ptr];
    instr_out    = w_empty ? '0 : w_head_instr;
    npc_out      = w_empty ? '0 : w_head_npc;
    valid_out    = !w_empty;
    full         = w_full;
    count        = r_count;
    halt_out     = !w_empty && (w_head_instr[31:26] == HALT_OP);
    halt_lock    = r_halt_lock;
    overflow     = r_overflow;
    underflow    = r_underflow;
  end

  // Entry write at the write pointer on every accepted push.
  always_ff @(posedge CLK) begin
    if (w_push_acc) begin
      r_instr_mem[r_wr_ptr] <= instr_in;
      r_npc_mem[r_wr_ptr]   <= npc_in;
    end
  end

  // Pointers, occupancy and halt lock. A flush overrides everything else.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_halt_lock <= 1'b0;
    end else if (flush) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_halt_lock <= 1'b0;
    end else begin
      if (w_pop_acc) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_push_is_halt) begin
          r_halt_lock <= 1'b1;
        end
      end
      if (w_push_acc && !w_pop_acc) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop_acc && !w_push_acc) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Sticky error flags. Only reset clears them; a flush leaves them set.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_drop_full) begin
        r_overflow <= 1'b1;
      end
      if (w_pop_on_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifid_queue.sv
// tb_ifid_queue: bench for the fetch-to-decode instruction queue.
module tb_ifid_queue;

  localparam int DEPTH = 4;

  // Clock and reset.
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        flush = 1'b0;
  logic        ihit = 1'b0;
  logic [31:0] instr_in = '0;
  logic [31:0] npc_in = '0;
  logic        pop = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] npc_out;
  logic        valid_out;
  logic        full;
  logic [2:0]  count;
  logic        halt_out;
  logic        halt_lock;
  logic        overflow;
  logic        underflow;

  always #5 CLK = ~CLK;

  ifid_queue #(.INSTR_W(32), .PC_W(32), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .flush(flush), .ihit(ihit),
    .instr_in(instr_in), .npc_in(npc_in), .pop(pop),
    .instr_out(instr_out), .npc_out(npc_out), .valid_out(valid_out),
    .full(full), .count(count), .halt_out(halt_out), .halt_lock(halt_lock),
    .overflow(overflow), .underflow(underflow)
  );

  // Scoreboard: expected {instr, npc} entries plus the expected flag state.
  logic [63:0] exp_q[$];
  logic        m_halt = 1'b0;
  logic        m_ovf  = 1'b0;
  logic        m_udf  = 1'b0;
  int          n_vec  = 0;
  int          n_err  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every observable output against the scoreboard.
  task automatic check_state();
    int          sz;
    logic [63:0] head;
    sz = exp_q.size();
    chk("count", 64'(count), 64'(sz));
    chk("valid_out", 64'(valid_out), 64'(sz != 0));
    chk("full", 64'(full), 64'(sz == DEPTH));
    chk("halt_lock", 64'(halt_lock), 64'(m_halt));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("underflow", 64'(underflow), 64'(m_udf));
    if (sz > 0) begin
      head = exp_q[0];
      chk("instr_out", 64'(instr_out), 64'(head[63:32]));
      chk("npc_out", 64'(npc_out), 64'(head[31:0]));
      chk("halt_out", 64'(halt_out), 64'(head[63:58] == 6'h3F));
    end else begin
      chk("instr_out_empty", 64'(instr_out), 64'd0);
      chk("npc_out_empty", 64'(npc_out), 64'd0);
      chk("halt_out_empty", 64'(halt_out), 64'd0);
    end
  endtask

  // Driver: present one cycle of stimulus, check the current state, update
  // the scoreboard with what the edge should do, then advance past the edge.
  task automatic step(input logic ih, input logic pp, input logic fl,
                      input logic [31:0] ins, input logic [31:0] np);
    int          sz;
    logic        pop_acc;
    logic        push_acc;
    logic [63:0] dropped;
    ihit = ih; pop = pp; flush = fl; instr_in = ins; npc_in = np;
    check_state();
    sz       = exp_q.size();
    pop_acc  = pp && !fl && (sz > 0);
    push_acc = ih && !fl && !m_halt && ((sz < DEPTH) || pop_acc);
    if (!fl && ih && (sz == DEPTH) && !pop_acc) m_ovf = 1'b1;
    if (!fl && pp && (sz == 0)) m_udf = 1'b1;
    if (fl) begin
      exp_q.delete();
      m_halt = 1'b0;
    end else begin
      if (pop_acc) dropped = exp_q.pop_front();
      if (push_acc) begin
        exp_q.push_back({ins, np});
        if (ins[31:26] == 6'h3F) m_halt = 1'b1;
      end
    end
    @(posedge CLK);
    #1;
    ihit = 1'b0; pop = 1'b0; flush = 1'b0;
  endtask

  typedef struct {
    logic        ih;
    logic        pp;
    logic [31:0] ins;
    logic [31:0] np;
    int          e_cnt;
    logic        e_full;
    logic [31:0] e_head;
  } vec_t;

  vec_t vt[17];

  initial begin
    // Fill and drain, then refill and run a push+pop while full.
    vt[0]  = '{1'b1, 1'b0, 32'h20010001, 32'd4,  1, 1'b0, 32'h20010001};
    vt[1]  = '{1'b1, 1'b0, 32'h20010002, 32'd8,  2, 1'b0, 32'h20010001};
    vt[2]  = '{1'b1, 1'b0, 32'h20010003, 32'd12, 3, 1'b0, 32'h20010001};
    vt[3]  = '{1'b1, 1'b0, 32'h20010004, 32'd16, 4, 1'b1, 32'h20010001};
    vt[4]  = '{1'b0, 1'b1, 32'h0,        32'd0,  3, 1'b0, 32'h20010002};
    vt[5]  = '{1'b0, 1'b1, 32'h0,        32'd0,  2, 1'b0, 32'h20010003};
    vt[6]  = '{1'b0, 1'b1, 32'h0,        32'd0,  1, 1'b0, 32'h20010004};
    vt[7]  = '{1'b0, 1'b1, 32'h0,        32'd0,  0, 1'b0, 32'h00000000};
    vt[8]  = '{1'b1, 1'b0, 32'h20010001, 32'd4,  1, 1'b0, 32'h20010001};
    vt[9]  = '{1'b1, 1'b0, 32'h20010002, 32'd8,  2, 1'b0, 32'h20010001};
    vt[10] = '{1'b1, 1'b0, 32'h20010003, 32'd12, 3, 1'b0, 32'h20010001};
    vt[11] = '{1'b1, 1'b0, 32'h20010004, 32'd16, 4, 1'b1, 32'h20010001};
    vt[12] = '{1'b1, 1'b1, 32'h8C220000, 32'd20, 4, 1'b1, 32'h20010002};
    vt[13] = '{1'b0, 1'b1, 32'h0,        32'd0,  3, 1'b0, 32'h20010003};
    vt[14] = '{1'b0, 1'b1, 32'h0,        32'd0,  2, 1'b0, 32'h20010004};
    vt[15] = '{1'b0, 1'b1, 32'h0,        32'd0,  1, 1'b0, 32'h8C220000};
    vt[16] = '{1'b0, 1'b1, 32'h0,        32'd0,  0, 1'b0, 32'h00000000};

    // Reset state, checked while RST is still high.
    #2;
    check_state();
    #5;
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Table-driven vectors.
    for (int i = 0; i < 17; i++) begin
      step(vt[i].ih, vt[i].pp, 1'b0, vt[i].ins, vt[i].np);
      chk("tbl_count", 64'(count), 64'(vt[i].e_cnt));
      chk("tbl_full", 64'(full), 64'(vt[i].e_full));
      chk("tbl_head", 64'(instr_out), 64'(vt[i].e_head));
    end
    chk("no_overflow_after_full_pushpop", 64'(overflow), 64'd0);

    // Overflow: a push while full is dropped. Underflow: a pop while empty.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 1'b0, 1'b0, 32'h30000000 + 32'(i), 32'h100 + 32'(4 * i));
    step(1'b1, 1'b0, 1'b0, 32'hDEAD0000, 32'hBAD);
    chk("ovf_count", 64'(count), 64'd4);
    chk("ovf_set", 64'(overflow), 64'd1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("udf_set", 64'(underflow), 64'd1);
    step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    chk("ovf_holds_flush", 64'(overflow), 64'd1);
    chk("udf_holds_flush", 64'(underflow), 64'd1);

    // Flush priority over a same-cycle push and pop, with count=3.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b0, 32'h40000000 + 32'($urandom_range(0, 65535)), 32'h200 + 32'(4 * i));
    chk("pre_flush_count", 64'(count), 64'd3);
    step(1'b1, 1'b1, 1'b1, 32'h11112222, 32'h44);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(valid_out), 64'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("flush_push_absent", 64'(instr_out), 64'd0);

    // Halt lock: the halt entry blocks later pushes and still drains.
    step(1'b1, 1'b0, 1'b0, 32'hFC000000, 32'h300);
    step(1'b1, 1'b0, 1'b0, 32'h00000020, 32'h304);
    chk("halt_count", 64'(count), 64'd1);
    chk("halt_lock_set", 64'(halt_lock), 64'd1);
    chk("halt_out_head", 64'(halt_out), 64'd1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("halt_drained", 64'(valid_out), 64'd0);
    step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    chk("halt_lock_cleared", 64'(halt_lock), 64'd0);
    step(1'b1, 1'b0, 1'b0, 32'h00000040, 32'h308);
    chk("post_halt_push", 64'(count), 64'd1);
    chk("post_halt_head", 64'(instr_out), 64'h40);

    // Wrap-around with random payloads across several pointer laps.
    for (int i = 0; i < 24; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
           32'($urandom_range(0, 32'h03FFFFFF)), 32'($urandom_range(0, 65535)));

    // Asynchronous reset between edges abandons queued entries.
    step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h50000001, 32'h400);
    step(1'b1, 1'b0, 1'b0, 32'h50000002, 32'h404);
    chk("pre_rst_count", 64'(count), 64'd2);
    #3;
    RST = 1'b1;
    #1;
    chk("async_rst_valid", 64'(valid_out), 64'd0);
    chk("async_rst_count", 64'(count), 64'd0);
    exp_q.delete();
    m_halt = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    check_state();
    @(posedge CLK);
    #3;
    RST = 1'b0;
    step(1'b1, 1'b0, 1'b0, 32'h60000001, 32'h500);
    chk("first_push_after_rst", 64'(count), 64'd1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    check_state();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
